// File: rtl/tmds_pkg.sv
// ---------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS deserializer: the four TMDS control-token
// code words, the word-alignment state enum, a few fixed widths/terminal
// values, and the control-token classifier used by every channel aligner.
// Ports: none (package).
// Optional feature macro used by the design files: TMDS_DESERIALIZER_SLIP_CNT_EN
// ---------------------------------------------------------------------------
package tmds_pkg;

  localparam int WORD_W = 10;
  localparam int HIST_W = 20;

  // Code words as vectors: bit 0 is the first bit on the wire.
  localparam logic [WORD_W-1:0] CTRL_TOKEN_0 = 10'b1101010100;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_1 = 10'b0010101011;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_2 = 10'b0101010100;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_3 = 10'b1010101011;

  // Last phase of the five-cycle word period and last legal slip offset.
  localparam logic [2:0] PHASE_LAST  = 3'd4;
  localparam logic [3:0] OFFSET_LAST = 4'd9;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_e;

  function automatic logic is_control_token(input logic [WORD_W-1:0] word);
    return (word == CTRL_TOKEN_0) || (word == CTRL_TOKEN_1) ||
           (word == CTRL_TOKEN_2) || (word == CTRL_TOKEN_3);
  endfunction

endpackage

// File: rtl/tmds_channel_aligner.sv
// ---------------------------------------------------------------------------
// tmds_channel_aligner
// One TMDS channel: keeps a 20-bit history of the DDR bit pairs, extracts a
// 10-bit word at the current slip offset once per word period, and runs the
// SEARCH/LOCKED alignment FSM that slips the offset until control tokens line
// up.
// Ports:
//   clk_i          five-times pixel clock
//   reset_i        synchronous active-high reset
//   pair_i         DDR bit pair, bit 0 earlier on the wire
//   word_strobe_i  high on the phase-4 cycle (word boundary)
//   word_o         registered recovered word, bit 0 first on the wire
//   locked_o       channel is word-aligned
//   slip_count_o   slips taken, saturating at 255
//                  (only with TMDS_DESERIALIZER_SLIP_CNT_EN)
// ---------------------------------------------------------------------------
module tmds_channel_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        pair_i,
  input  logic              word_strobe_i,
  output logic [WORD_W-1:0] word_o,
  output logic              locked_o
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
  ,
  output logic [7:0]        slip_count_o
`endif
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SEARCH_TIMEOUT);

  logic [HIST_W-1:0] history_q, history_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_q, run_d, run_inc;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  align_state_e      state_q, state_d;
  logic [WORD_W-1:0] word_q, word_sel;
  logic [4:0]        sel_base;
  logic              token;

  // Newest pair enters at the top, so offset 0 picks the ten newest bits and
  // larger offsets reach back into older bits.
  assign history_d = {pair_i[1], pair_i[0], history_q[HIST_W-1:2]};
  assign sel_base  = 5'd10 - {1'b0, offset_q};
  assign word_sel  = history_d[sel_base +: WORD_W];
  assign token     = is_control_token(word_sel);

  // Counters hold at their terminal value rather than wrapping.
  assign run_inc  = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
  assign idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;

  // Alignment FSM, evaluated only on word boundaries. In SEARCH a token clears
  // the idle count, so a slip and a lock can never fall on the same word.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    idle_d   = idle_q;
    if (word_strobe_i) begin
      case (state_q)
        SEARCH: begin
          if (token) begin
            idle_d = '0;
            run_d  = run_inc;
            if (run_inc == RUN_MAX) begin
              state_d = LOCKED;
              run_d   = '0;
            end
          end else begin
            run_d  = '0;
            idle_d = idle_inc;
            if (idle_inc == IDLE_MAX) begin
              offset_d = (offset_q == OFFSET_LAST) ? 4'd0 : offset_q + 4'd1;
              idle_d   = '0;
            end
          end
        end
        LOCKED: begin
          if (token) begin
            idle_d = '0;
          end else begin
            idle_d = idle_inc;
            if (idle_inc == IDLE_MAX) begin
              state_d = SEARCH;
              idle_d  = '0;
              run_d   = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      history_q <= '0;
      offset_q  <= '0;
      run_q     <= '0;
      idle_q    <= '0;
      state_q   <= SEARCH;
      word_q    <= '0;
    end else begin
      history_q <= history_d;
      offset_q  <= offset_d;
      run_q     <= run_d;
      idle_q    <= idle_d;
      state_q   <= state_d;
      if (word_strobe_i) begin
        word_q <= word_sel;
      end
    end
  end

  assign word_o   = word_q;
  assign locked_o = (state_q == LOCKED);

`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
  logic [7:0] slip_cnt_q;
  logic       slip;

  // The offset only ever moves on a slip, so a change marks one.
  assign slip = (offset_d != offset_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slip_cnt_q <= '0;
    end else if (slip && (slip_cnt_q != 8'hFF)) begin
      slip_cnt_q <= slip_cnt_q + 8'd1;
    end
  end

  assign slip_count_o = slip_cnt_q;
`endif

endmodule

// File: rtl/tmds_deserializer.sv
// ---------------------------------------------------------------------------
// tmds_deserializer
// Multi-channel TMDS word recovery. A shared five-phase counter marks word
// boundaries; each channel independently aligns to control tokens in its own
// tmds_channel_aligner.
// Ports:
//   clk_pixel_x5  five-times pixel clock (single clock)
//   reset         synchronous active-high reset
//   serial_pair   per-channel DDR bit pair, bit 0 earlier on the wire
//   word_out      per-channel recovered word, bit 0 first on the wire
//   word_valid    one-cycle strobe, once every five cycles
//   locked        per-channel alignment lock
//   slip_count    per-channel slip counter, saturating at 255
//                 (only with TMDS_DESERIALIZER_SLIP_CNT_EN)
// ---------------------------------------------------------------------------
module tmds_deserializer
  import tmds_pkg::*;
#(
  parameter int NUM_CHANNELS   = 3,
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048
) (
  input  logic                              clk_pixel_x5,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0][1:0]      serial_pair,
  output logic [NUM_CHANNELS-1:0][WORD_W-1:0] word_out,
  output logic                              word_valid,
  output logic [NUM_CHANNELS-1:0]           locked
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
  ,
  output logic [NUM_CHANNELS-1:0][7:0]      slip_count
`endif
);

  logic [2:0] phase_q, phase_d;
  logic       word_valid_q;
  logic       word_strobe;

  // The phase-4 cycle completes a word; its registered result and the valid
  // strobe appear together on the following cycle.
  assign word_strobe = (phase_q == PHASE_LAST);
  assign phase_d     = word_strobe ? 3'd0 : phase_q + 3'd1;

  always_ff @(posedge clk_pixel_x5) begin
    if (reset) begin
      phase_q      <= '0;
      word_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      word_valid_q <= word_strobe;
    end
  end

  assign word_valid = word_valid_q;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    tmds_channel_aligner #(
      .LOCK_COUNT     (LOCK_COUNT),
      .SEARCH_TIMEOUT (SEARCH_TIMEOUT)
    ) u_aligner (
      .clk_i         (clk_pixel_x5),
      .reset_i       (reset),
      .pair_i        (serial_pair[ch]),
      .word_strobe_i (word_strobe),
      .word_o        (word_out[ch]),
      .locked_o      (locked[ch])
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
      ,
      .slip_count_o  (slip_count[ch])
`endif
    );
  end

endmodule

// File: tb/tb_tmds_deserializer.sv
// ---------------------------------------------------------------------------
// tb_tmds_deserializer
// Directed bench for tmds_deserializer with three channels, LOCK_COUNT=8 and
// SEARCH_TIMEOUT=16. Bits are queued in wire order and fed two per cycle.
// Slip counts are checked when TMDS_DESERIALIZER_SLIP_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_tmds_deserializer;

  localparam int NCH = 3;
  localparam logic [9:0]  TOK   = 10'b1101010100;
  localparam logic [9:0]  DATAW = 10'b0000011111;
  localparam logic [29:0] TOK3  = {TOK, TOK, TOK};
  localparam logic [29:0] DATA3 = {DATAW, DATAW, DATAW};

  logic                  clk;
  logic                  reset;
  logic [NCH-1:0][1:0]   serialPair;
  logic [NCH-1:0][9:0]   wordOut;
  logic                  wordValid;
  logic [NCH-1:0]        locked;
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
  logic [NCH-1:0][7:0]   slipCount;
`endif

  int checks = 0;
  int errors = 0;

  logic [NCH-1:0] bitQ[$];

  tmds_deserializer #(
    .NUM_CHANNELS   (NCH),
    .LOCK_COUNT     (8),
    .SEARCH_TIMEOUT (16)
  ) dut (
    .clk_pixel_x5 (clk),
    .reset        (reset),
    .serial_pair  (serialPair),
    .word_out     (wordOut),
    .word_valid   (wordValid),
    .locked       (locked)
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
    ,
    .slip_count   (slipCount)
`endif
  );

  // Free-running pixel-x5 clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Queue n copies of a word on every channel, first wire bit first.
  task automatic pushWord(input logic [9:0] w, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 10; i++)
        bitQ.push_back({NCH{w[i]}});
  endtask

  // Queue the tail of a word starting at wire bit 'first'.
  task automatic pushTail(input logic [9:0] w, input int first);
    for (int i = first; i < 10; i++)
      bitQ.push_back({NCH{w[i]}});
  endtask

  // Drive nTicks cycles from the bit queue (zeros once it runs dry); returns
  // 1 time unit after the last rising edge so outputs are stable.
  task automatic applyStimulus(input int nTicks);
    logic [NCH-1:0] e0, e1;
    for (int t = 0; t < nTicks; t++) begin
      e0 = (bitQ.size() > 0) ? bitQ.pop_front() : '0;
      e1 = (bitQ.size() > 0) ? bitQ.pop_front() : '0;
      for (int ch = 0; ch < NCH; ch++)
        serialPair[ch] = {e1[ch], e0[ch]};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Two reset cycles with the bit queue flushed, outputs checked, then release.
  task automatic doReset(input string tag);
    reset = 1'b1;
    bitQ.delete();
    applyStimulus(2);
    checkOutput({tag, "_valid"}, {31'd0, wordValid}, 32'd0);
    checkOutput({tag, "_locked"}, {29'd0, locked}, 32'd0);
    checkOutput({tag, "_word"}, {2'd0, wordOut}, 32'd0);
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
    checkOutput({tag, "_slips"}, {8'd0, slipCount}, 32'd0);
`endif
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    serialPair = '0;

    // Aligned token stream: lock on the 8th word.
    doReset("rst0");
    pushWord(TOK, 8);
    applyStimulus(4);
    checkOutput("a_valid_before_first", {31'd0, wordValid}, 32'd0);
    applyStimulus(1);
    checkOutput("a_valid_first", {31'd0, wordValid}, 32'd1);
    checkOutput("a_word_first", {2'd0, wordOut}, {2'd0, TOK3});
    checkOutput("a_locked_first", {29'd0, locked}, 32'd0);
    applyStimulus(1);
    checkOutput("a_valid_one_cycle", {31'd0, wordValid}, 32'd0);
    applyStimulus(29);
    checkOutput("a_valid_word7", {31'd0, wordValid}, 32'd1);
    checkOutput("a_locked_word7", {29'd0, locked}, 32'd0);
    applyStimulus(5);
    checkOutput("a_locked_word8", {29'd0, locked}, 32'd7);
    checkOutput("a_word_word8", {2'd0, wordOut}, {2'd0, TOK3});
    checkOutput("a_valid_word8", {31'd0, wordValid}, 32'd1);

    // Seven tokens, a data word, then eight tokens.
    doReset("rst1");
    pushWord(TOK, 7);
    pushWord(DATAW, 1);
    pushWord(TOK, 8);
    applyStimulus(40);
    checkOutput("b_word_data", {2'd0, wordOut}, {2'd0, DATA3});
    checkOutput("b_locked_after_data", {29'd0, locked}, 32'd0);
    applyStimulus(35);
    checkOutput("b_locked_tok7", {29'd0, locked}, 32'd0);
    applyStimulus(5);
    checkOutput("b_locked_tok8", {29'd0, locked}, 32'd7);

    // Sixteen non-token words drop lock; offset stays so tokens relock.
    applyStimulus(75);
    checkOutput("c_locked_idle15", {29'd0, locked}, 32'd7);
    applyStimulus(5);
    checkOutput("c_locked_idle16", {29'd0, locked}, 32'd0);
    checkOutput("c_word_idle16", {2'd0, wordOut}, 32'd0);
    pushWord(TOK, 8);
    applyStimulus(35);
    checkOutput("c_relock_tok7", {29'd0, locked}, 32'd0);
    applyStimulus(5);
    checkOutput("c_relock_tok8", {29'd0, locked}, 32'd7);

    // Reset pulsed two cycles after a word_valid while locked.
    applyStimulus(2);
    checkOutput("d_locked_pre_reset", {29'd0, locked}, 32'd7);
    reset = 1'b1;
    bitQ.delete();
    applyStimulus(1);
    checkOutput("d_locked_in_reset", {29'd0, locked}, 32'd0);
    checkOutput("d_word_in_reset", {2'd0, wordOut}, 32'd0);
    checkOutput("d_valid_in_reset", {31'd0, wordValid}, 32'd0);
    reset = 1'b0;
    pushWord(TOK, 1);
    applyStimulus(4);
    checkOutput("d_valid_release5", {31'd0, wordValid}, 32'd0);
    applyStimulus(1);
    checkOutput("d_valid_release6", {31'd0, wordValid}, 32'd1);
    checkOutput("d_word_release6", {2'd0, wordOut}, {2'd0, TOK3});

    // Stream advanced by 3 bits: three slips of 16 words each, then lock.
    doReset("rst2");
    pushTail(TOK, 3);
    pushWord(TOK, 60);
    applyStimulus(235);
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
    checkOutput("e_slips_word47", {8'd0, slipCount}, {8'd0, {NCH{8'd2}}});
`endif
    applyStimulus(5);
    checkOutput("e_locked_word48", {29'd0, locked}, 32'd0);
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
    checkOutput("e_slips_word48", {8'd0, slipCount}, {8'd0, {NCH{8'd3}}});
`endif
    applyStimulus(35);
    checkOutput("e_locked_word55", {29'd0, locked}, 32'd0);
    applyStimulus(5);
    checkOutput("e_locked_word56", {29'd0, locked}, 32'd7);
    checkOutput("e_word_word56", {2'd0, wordOut}, {2'd0, TOK3});
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
    checkOutput("e_slips_final", {8'd0, slipCount}, {8'd0, {NCH{8'd3}}});
`endif

    // 160 zero words walk the offset through 9 and wrap it to 0.
    doReset("rst3");
    applyStimulus(800);
    checkOutput("f_locked_after_wrap", {29'd0, locked}, 32'd0);
`ifdef TMDS_DESERIALIZER_SLIP_CNT_EN
    checkOutput("f_slips_after_wrap", {8'd0, slipCount}, {8'd0, {NCH{8'd10}}});
`endif
    pushWord(TOK, 8);
    applyStimulus(35);
    checkOutput("f_locked_tok7", {29'd0, locked}, 32'd0);
    applyStimulus(5);
    checkOutput("f_locked_tok8", {29'd0, locked}, 32'd7);
    checkOutput("f_word_tok8", {2'd0, wordOut}, {2'd0, TOK3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
